// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op codes, FSM states and op classification shared by the ALU files
package seq_alu_pkg;
  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_NOR   = 4'b0011,
    OP_ADD   = 4'b0100,
    OP_ADDU  = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SUBU  = 4'b0111,
    OP_SLT   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_MULT  = 4'b1010,
    OP_MULTU = 4'b1011,
    OP_DIV   = 4'b1100,
    OP_DIVU  = 4'b1101
  } alu_op_e;
  typedef enum logic {IDLE, CALC} state_e;
  function automatic logic is_iter(input logic [3:0] op, input logic b_nz);
    return op == OP_MULT || op == OP_MULTU || ((op == OP_DIV || op == OP_DIVU) && b_nz);
  endfunction
endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: start/busy/done request bus; master issues op and operands, slave returns result, hi and flags
interface seq_alu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             ovf;
  logic             div0;
  modport master(output start, alu_op, a, b, input busy, done, result, hi, zero, ovf, div0);
  modport slave(input start, alu_op, a, b, output busy, done, result, hi, zero, ovf, div0);
endinterface

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: radix-2 shift-add multiplier / restoring divider on magnitudes; load latches, step iterates, last exposes the sign-fixed final result
module seq_alu_muldiv #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [2*WIDTH-1:0] p, p_n, p_mul, p_div, prod;
  logic [WIDTH-1:0] m, a_mag, b_mag, q, r;
  logic [WIDTH:0] madd, rsh, diff;
  logic [CW-1:0] cnt;
  logic div_r, neg_q, neg_r, a_neg, b_neg, ge;
  assign a_neg = sgn && a[WIDTH-1];
  assign b_neg = sgn && b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign last = step && cnt == LAST;
  always_comb begin
    madd = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m & {WIDTH{p[0]}}};
    p_mul = {madd, p[WIDTH-1:1]};
    rsh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff = rsh - {1'b0, m};
    ge = ~diff[WIDTH];
    p_div = {ge ? diff[WIDTH-1:0] : rsh[WIDTH-1:0], p[WIDTH-2:0], ge};
    p_n = div_r ? p_div : p_mul;
    prod = neg_q ? -p_n : p_n;
    q = p_n[WIDTH-1:0];
    r = p_n[2*WIDTH-1:WIDTH];
    lo = div_r ? (neg_q ? -q : q) : prod[WIDTH-1:0];
    hi = div_r ? (neg_r ? -r : r) : prod[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      m <= '0;
      cnt <= '0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      p <= {{WIDTH{1'b0}}, a_mag};
      m <= b_mag;
      cnt <= '0;
      div_r <= is_div;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end else if (step) begin
      p <= p_n;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: clocked MIPS ALU with single-cycle logic/add/slt and iterative mul/div behind a start/busy/done bus
module seq_alu import seq_alu_pkg::*; #(parameter int WIDTH = 32) (
  input logic       clk,
  input logic       rst,
  seq_alu_if.slave  bus
);
  logic [WIDTH-1:0] sum, dif, s_res, s_hi, n_res, n_hi, md_lo, md_hi, result_q, hi_q;
  logic s_ovf, s_div0, n_ovf, n_div0, n_done, load, last, iter, is_div, sgn, calc;
  logic done_q, zero_q, ovf_q, div0_q;
  state_e state, state_n;
  always_comb begin
    sum = bus.a + bus.b;
    dif = bus.a - bus.b;
    s_res = '0;
    s_hi = '0;
    s_ovf = 1'b0;
    s_div0 = 1'b0;
    case (bus.alu_op)
      OP_AND:  s_res = bus.a & bus.b;
      OP_OR:   s_res = bus.a | bus.b;
      OP_NOR:  s_res = ~(bus.a | bus.b);
      OP_ADD: begin
        s_res = sum;
        s_ovf = bus.a[WIDTH-1] == bus.b[WIDTH-1] && sum[WIDTH-1] != bus.a[WIDTH-1];
      end
      OP_ADDU: s_res = sum;
      OP_SUB: begin
        s_res = dif;
        s_ovf = bus.a[WIDTH-1] != bus.b[WIDTH-1] && dif[WIDTH-1] != bus.a[WIDTH-1];
      end
      OP_SUBU: s_res = dif;
      OP_SLT:  s_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_SLTU: s_res = WIDTH'(bus.a < bus.b);
      OP_DIV, OP_DIVU: begin
        s_res = '1;
        s_hi = bus.a;
        s_div0 = 1'b1;
      end
      default: ;
    endcase
  end
  assign iter = is_iter(bus.alu_op, bus.b != '0);
  assign is_div = bus.alu_op == OP_DIV || bus.alu_op == OP_DIVU;
  assign sgn = bus.alu_op == OP_MULT || bus.alu_op == OP_DIV;
  assign calc = state == CALC;
  assign load = state == IDLE && bus.start && iter;
  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk(clk),
    .rst(rst),
    .load(load),
    .step(calc),
    .is_div(is_div),
    .sgn(sgn),
    .a(bus.a),
    .b(bus.b),
    .last(last),
    .lo(md_lo),
    .hi(md_hi)
  );
  always_comb begin
    state_n = load ? CALC : (last ? IDLE : state);
    n_done = calc ? last : bus.start && !iter;
    n_res = calc ? md_lo : s_res;
    n_hi = calc ? md_hi : s_hi;
    n_ovf = !calc && s_ovf;
    n_div0 = !calc && s_div0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done_q <= 1'b0;
      result_q <= '0;
      hi_q <= '0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      state <= state_n;
      done_q <= n_done;
      if (n_done) begin
        result_q <= n_res;
        hi_q <= n_hi;
        zero_q <= n_res == '0;
        ovf_q <= n_ovf;
        div0_q <= n_div0;
      end
    end
  end
  assign bus.busy = calc;
  assign bus.done = done_q;
  assign bus.result = result_q;
  assign bus.hi = hi_q;
  assign bus.zero = zero_q;
  assign bus.ovf = ovf_q;
  assign bus.div0 = div0_q;
endmodule
